// File: rtl/bsg_tag_pkg.sv
// Shared types and default sizing for the bsg_tag transmit path.
package bsg_tag_pkg;

  localparam int BSG_TAG_ELS               = 16;
  localparam int BSG_TAG_MAX_PAYLOAD_WIDTH = 8;
  localparam int BSG_TAG_RESET_ONES        = 32;
  localparam int BSG_TAG_GAP_ZEROS         = 2;

  localparam int BSG_TAG_LG_ELS = $clog2(BSG_TAG_ELS);
  localparam int BSG_TAG_LG_LEN = $clog2(BSG_TAG_MAX_PAYLOAD_WIDTH + 1);

  // Transmitter frame position; each non-idle state is one field of the frame.
  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_MRESET  = 3'd1,
    TX_START   = 3'd2,
    TX_LEN     = 3'd3,
    TX_DNR     = 3'd4,
    TX_ID      = 3'd5,
    TX_PAYLOAD = 3'd6,
    TX_GAP     = 3'd7
  } bsg_tag_tx_state_e;

  // One tag command as seen at the handshake, sized for the default build.
  typedef struct packed {
    logic                                 master_reset;
    logic [BSG_TAG_LG_ELS-1:0]            nodeid;
    logic                                 data_not_reset;
    logic [BSG_TAG_LG_LEN-1:0]            len;
    logic [BSG_TAG_MAX_PAYLOAD_WIDTH-1:0] payload;
  } bsg_tag_tx_cmd_s;

  function automatic int bsg_tag_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_tag_packet_tx.sv
// Serializes tag commands onto the bsg_tag en/data pads, one bit per clock, LSB first.
module bsg_tag_packet_tx
  import bsg_tag_pkg::*;
#(
  parameter int els_p               = BSG_TAG_ELS,
  parameter int max_payload_width_p = BSG_TAG_MAX_PAYLOAD_WIDTH,
  parameter int reset_ones_p        = BSG_TAG_RESET_ONES,
  parameter int gap_zeros_p         = BSG_TAG_GAP_ZEROS,
  localparam int lg_els_lp          = $clog2(els_p),
  localparam int lg_len_lp          = $clog2(max_payload_width_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic                           master_reset_i,
  input  logic [lg_els_lp-1:0]           nodeid_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_len_lp-1:0]           len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           ready_o,
  output logic                           tag_en_o,
  output logic                           tag_data_o,
  output logic                           done_o
);

  // The single bit counter must reach the last index of the widest field.
  localparam int max_field_lp = bsg_tag_max(bsg_tag_max(reset_ones_p, max_payload_width_p),
                                            bsg_tag_max(gap_zeros_p,
                                                        bsg_tag_max(lg_len_lp, lg_els_lp)));
  localparam int ctr_w_lp = (max_field_lp > 1) ? $clog2(max_field_lp) : 1;

  typedef logic [ctr_w_lp-1:0]  ctr_t;
  typedef logic [lg_len_lp-1:0] len_t;

  localparam ctr_t len_last_lp    = ctr_t'(lg_len_lp - 1);
  localparam ctr_t id_last_lp     = ctr_t'(lg_els_lp - 1);
  localparam ctr_t gap_last_lp    = ctr_t'(gap_zeros_p - 1);
  localparam ctr_t mreset_last_lp = ctr_t'(reset_ones_p - 1);
  localparam len_t len_max_lp     = len_t'(max_payload_width_p);

  bsg_tag_tx_state_e state_q, state_n;
  ctr_t              cnt_q, cnt_n;
  ctr_t              pay_last;

  len_t                           len_q, len_n;
  len_t                           len_sr_q, len_sr_n;
  logic                           dnr_q, dnr_n;
  logic [lg_els_lp-1:0]           id_sr_q, id_sr_n;
  logic [max_payload_width_p-1:0] pay_sr_q, pay_sr_n;

  logic data_n, en_n, done_n, ready_n;
  len_t len_clamped;

  // Oversized lengths are illegal; the hardware sends max_payload_width_p bits instead.
  assign len_clamped = (len_i > len_max_lp) ? len_max_lp : len_i;
  assign pay_last    = ctr_t'(len_q) - ctr_t'(1);

  // Next-state, field shifting and the next values of the registered pad outputs.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q + ctr_t'(1);
    len_n    = len_q;
    len_sr_n = len_sr_q;
    dnr_n    = dnr_q;
    id_sr_n  = id_sr_q;
    pay_sr_n = pay_sr_q;
    data_n   = 1'b0;
    en_n     = 1'b0;
    done_n   = 1'b0;
    ready_n  = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        cnt_n = '0;
        if (v_i && ready_o) begin
          state_n  = master_reset_i ? TX_MRESET : TX_START;
          len_n    = len_clamped;
          len_sr_n = len_clamped;
          dnr_n    = data_not_reset_i;
          id_sr_n  = nodeid_i;
          pay_sr_n = payload_i;
        end
      end
      TX_MRESET: begin
        if (cnt_q == mreset_last_lp) begin
          state_n = TX_GAP;
          cnt_n   = '0;
        end
      end
      TX_START: begin
        state_n = TX_LEN;
        cnt_n   = '0;
      end
      TX_LEN: begin
        len_sr_n = len_sr_q >> 1;
        if (cnt_q == len_last_lp) begin
          state_n = TX_DNR;
          cnt_n   = '0;
        end
      end
      TX_DNR: begin
        state_n = TX_ID;
        cnt_n   = '0;
      end
      TX_ID: begin
        id_sr_n = id_sr_q >> 1;
        if (cnt_q == id_last_lp) begin
          state_n = (len_q != '0) ? TX_PAYLOAD : TX_GAP;
          cnt_n   = '0;
        end
      end
      TX_PAYLOAD: begin
        pay_sr_n = pay_sr_q >> 1;
        if (cnt_q == pay_last) begin
          state_n = TX_GAP;
          cnt_n   = '0;
        end
      end
      TX_GAP: begin
        if (cnt_q == gap_last_lp) begin
          state_n = TX_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = TX_IDLE;
        cnt_n   = '0;
      end
    endcase

    unique case (state_n)
      TX_START,
      TX_MRESET:  data_n = 1'b1;
      TX_LEN:     data_n = len_sr_n[0];
      TX_DNR:     data_n = dnr_n;
      TX_ID:      data_n = id_sr_n[0];
      TX_PAYLOAD: data_n = pay_sr_n[0];
      default:    data_n = 1'b0;
    endcase

    en_n    = (state_n != TX_IDLE) && (state_n != TX_GAP);
    done_n  = (state_n == TX_GAP) && (cnt_n == gap_last_lp);
    ready_n = (state_n == TX_IDLE);
  end

  // State, bit counter and latched command fields.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      len_sr_q <= '0;
      dnr_q    <= 1'b0;
      id_sr_q  <= '0;
      pay_sr_q <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      len_q    <= len_n;
      len_sr_q <= len_sr_n;
      dnr_q    <= dnr_n;
      id_sr_q  <= id_sr_n;
      pay_sr_q <= pay_sr_n;
    end
  end

  // Pad and handshake outputs come straight from flops so the chip sees clean edges.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_data_o <= 1'b0;
      tag_en_o   <= 1'b0;
      done_o     <= 1'b0;
      ready_o    <= 1'b0;
    end else begin
      tag_data_o <= data_n;
      tag_en_o   <= en_n;
      done_o     <= done_n;
      ready_o    <= ready_n;
    end
  end

  // A packet command must never carry more payload bits than the field can hold.
  len_in_range_a : assert property (@(posedge clk_i) disable iff (reset_i)
    (v_i && ready_o && !master_reset_i) |-> (len_i <= len_max_lp));

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
// Directed checks of the tag serializer, with a simple frame decoder standing in for the chip side.
module tb_bsg_tag_packet_tx;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       v_i = 1'b0;
  logic       master_reset_i = 1'b0;
  logic [3:0] nodeid_i = '0;
  logic       data_not_reset_i = 1'b0;
  logic [3:0] len_i = '0;
  logic [7:0] payload_i = '0;
  logic       ready_o, tag_en_o, tag_data_o, done_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_d, cap_e, cap_done, cap_ready;
  logic [63:0] exp_d, exp_e, exp_done, exp_ready;

  logic [63:0] rx_bits = '0;
  int          rx_n = 0;
  int          rx_frames = 0;
  logic [3:0]  rx_len = '0;
  logic [3:0]  rx_id = '0;
  logic        rx_dnr = 1'b0;
  logic        rx_mreset = 1'b0;
  logic [7:0]  rx_payload = '0;

  bsg_tag_packet_tx dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .v_i              (v_i),
    .master_reset_i   (master_reset_i),
    .nodeid_i         (nodeid_i),
    .data_not_reset_i (data_not_reset_i),
    .len_i            (len_i),
    .payload_i        (payload_i),
    .ready_o          (ready_o),
    .tag_en_o         (tag_en_o),
    .tag_data_o       (tag_data_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Chip-side receiver: samples the pads on the rising edge and decodes each enabled run.
  always @(posedge clk_i) begin
    if (reset_i) begin
      rx_n    = 0;
      rx_bits = '0;
    end else if (tag_en_o) begin
      if (rx_n < 64) rx_bits[rx_n] = tag_data_o;
      rx_n++;
    end else if (rx_n != 0) begin
      rx_frames++;
      if (rx_n == 32 && rx_bits[31:0] == 32'hFFFF_FFFF) begin
        rx_mreset = 1'b1;
      end else begin
        rx_mreset  = 1'b0;
        rx_len     = rx_bits[4:1];
        rx_dnr     = rx_bits[5];
        rx_id      = rx_bits[9:6];
        rx_payload = 8'(rx_bits >> 10);
      end
      rx_n    = 0;
      rx_bits = '0;
    end
  end

  task automatic issue(input logic mr, input logic [3:0] id, input logic dnr,
                       input logic [3:0] len, input logic [7:0] pl);
    master_reset_i   = mr;
    nodeid_i         = id;
    data_not_reset_i = dnr;
    len_i            = len;
    payload_i        = pl;
    v_i              = 1'b1;
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic capture(input int n);
    cap_d = '0; cap_e = '0; cap_done = '0; cap_ready = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      cap_d[k]     = tag_data_o;
      cap_e[k]     = tag_en_o;
      cap_done[k]  = done_o;
      cap_ready[k] = ready_o;
    end
  endtask

  // Builds the expected pad sequence of one command starting at bit offset off.
  function automatic int add_frame(input int off, input logic mr, input logic [3:0] id,
                                   input logic dnr, input logic [3:0] len, input logic [7:0] pl);
    int p = off;
    if (mr) begin
      for (int i = 0; i < 32; i++) begin exp_d[p] = 1'b1; exp_e[p] = 1'b1; p++; end
    end else begin
      exp_d[p] = 1'b1; exp_e[p] = 1'b1; p++;
      for (int i = 0; i < 4; i++) begin exp_d[p] = len[i]; exp_e[p] = 1'b1; p++; end
      exp_d[p] = dnr; exp_e[p] = 1'b1; p++;
      for (int i = 0; i < 4; i++) begin exp_d[p] = id[i]; exp_e[p] = 1'b1; p++; end
      for (int i = 0; i < int'(len); i++) begin exp_d[p] = pl[i]; exp_e[p] = 1'b1; p++; end
    end
    p += 2;
    exp_done[p-1] = 1'b1;
    return p - off;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (tag_en_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", tag_en_o); end
    checks++; if (tag_data_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_data: got %b expected 0", tag_data_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_o); end
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: got %b expected 1", ready_o); end
  endtask

  task automatic test_packet();
    int f0 = rx_frames;
    issue(1'b0, 4'd3, 1'b1, 4'd4, 8'h0A);
    capture(17);
    checks++; if (cap_d !== 64'h28E9) begin errors++; $display("[TB] FAIL packet_data: got %h expected %h", cap_d, 64'h28E9); end
    checks++; if (cap_e !== 64'h3FFF) begin errors++; $display("[TB] FAIL packet_en: got %h expected %h", cap_e, 64'h3FFF); end
    checks++; if (cap_done !== 64'h8000) begin errors++; $display("[TB] FAIL packet_done: got %h expected %h", cap_done, 64'h8000); end
    checks++; if (cap_ready !== 64'h10000) begin errors++; $display("[TB] FAIL packet_ready: got %h expected %h", cap_ready, 64'h10000); end
    checks++; if (rx_frames - f0 !== 1) begin errors++; $display("[TB] FAIL packet_rx_count: got %0d expected 1", rx_frames - f0); end
    checks++; if ({rx_id, rx_dnr, rx_len, rx_payload} !== {4'd3, 1'b1, 4'd4, 8'h0A}) begin
      errors++; $display("[TB] FAIL packet_rx_fields: got id %0d dnr %b len %0d payload %h expected id 3 dnr 1 len 4 payload 0a",
                         rx_id, rx_dnr, rx_len, rx_payload);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_len0();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL len0_ready_before: got %b expected 1", ready_o); end
    issue(1'b0, 4'd15, 1'b0, 4'd0, 8'hFF);
    capture(13);
    checks++; if (cap_d !== 64'h3C1) begin errors++; $display("[TB] FAIL len0_data: got %h expected %h", cap_d, 64'h3C1); end
    checks++; if (cap_e !== 64'h3FF) begin errors++; $display("[TB] FAIL len0_en: got %h expected %h", cap_e, 64'h3FF); end
    checks++; if (cap_done !== 64'h800) begin errors++; $display("[TB] FAIL len0_done: got %h expected %h", cap_done, 64'h800); end
    checks++; if (cap_ready !== 64'h1000) begin errors++; $display("[TB] FAIL len0_ready: got %h expected %h", cap_ready, 64'h1000); end
    checks++; if ({rx_id, rx_dnr, rx_len, rx_payload} !== {4'd15, 1'b0, 4'd0, 8'h00}) begin
      errors++; $display("[TB] FAIL len0_rx_fields: got id %0d dnr %b len %0d payload %h expected id 15 dnr 0 len 0 payload 00",
                         rx_id, rx_dnr, rx_len, rx_payload);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_master_reset();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL mreset_ready_before: got %b expected 1", ready_o); end
    issue(1'b1, 4'd9, 1'b1, 4'd3, 8'h5A);
    capture(35);
    checks++; if (cap_d !== 64'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mreset_data: got %h expected %h", cap_d, 64'hFFFF_FFFF); end
    checks++; if (cap_e !== 64'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mreset_en: got %h expected %h", cap_e, 64'hFFFF_FFFF); end
    checks++; if (cap_done !== 64'h2_0000_0000) begin errors++; $display("[TB] FAIL mreset_done: got %h expected %h", cap_done, 64'h2_0000_0000); end
    checks++; if (cap_ready !== 64'h4_0000_0000) begin errors++; $display("[TB] FAIL mreset_ready: got %h expected %h", cap_ready, 64'h4_0000_0000); end
    checks++; if (rx_mreset !== 1'b1) begin errors++; $display("[TB] FAIL mreset_rx: got %b expected 1", rx_mreset); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    int f0 = rx_frames;
    int la, lb;
    exp_d = '0; exp_e = '0; exp_done = '0; exp_ready = '0;
    la = add_frame(0, 1'b0, 4'd6, 1'b1, 4'd2, 8'h02);
    lb = add_frame(la + 1, 1'b0, 4'd12, 1'b0, 4'd8, 8'h5C);
    exp_ready[la] = 1'b1;
    exp_ready[la + lb + 1] = 1'b1;
    master_reset_i = 1'b0; nodeid_i = 4'd6; data_not_reset_i = 1'b1; len_i = 4'd2; payload_i = 8'h02;
    v_i = 1'b1;
    @(posedge clk_i); #1;
    nodeid_i = 4'd12; data_not_reset_i = 1'b0; len_i = 4'd8; payload_i = 8'h5C;
    cap_d = '0; cap_e = '0; cap_done = '0; cap_ready = '0;
    for (int k = 0; k < la + lb + 2; k++) begin
      @(negedge clk_i);
      cap_d[k] = tag_data_o; cap_e[k] = tag_en_o; cap_done[k] = done_o; cap_ready[k] = ready_o;
      if (k == la) begin
        @(posedge clk_i); #1;
        v_i = 1'b0;
      end
    end
    checks++; if (cap_d !== exp_d) begin errors++; $display("[TB] FAIL b2b_data: got %h expected %h", cap_d, exp_d); end
    checks++; if (cap_e !== exp_e) begin errors++; $display("[TB] FAIL b2b_en: got %h expected %h", cap_e, exp_e); end
    checks++; if (cap_done !== exp_done) begin errors++; $display("[TB] FAIL b2b_done: got %h expected %h", cap_done, exp_done); end
    checks++; if (cap_ready !== exp_ready) begin errors++; $display("[TB] FAIL b2b_ready: got %h expected %h", cap_ready, exp_ready); end
    checks++; if (rx_frames - f0 !== 2) begin errors++; $display("[TB] FAIL b2b_rx_count: got %0d expected 2", rx_frames - f0); end
    checks++; if ({rx_id, rx_dnr, rx_len, rx_payload} !== {4'd12, 1'b0, 4'd8, 8'h5C}) begin
      errors++; $display("[TB] FAIL b2b_rx_fields: got id %0d dnr %b len %0d payload %h expected id 12 dnr 0 len 8 payload 5c",
                         rx_id, rx_dnr, rx_len, rx_payload);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    int f0;
    int lc;
    issue(1'b0, 4'd2, 1'b1, 4'd8, 8'hFF);
    for (int k = 0; k < 12; k++) @(negedge clk_i);
    checks++; if ({tag_en_o, tag_data_o} !== 2'b11) begin errors++; $display("[TB] FAIL midreset_active: got %b expected 11", {tag_en_o, tag_data_o}); end
    #1;
    reset_i = 1'b1;
    #1;
    checks++; if ({tag_en_o, tag_data_o, done_o, ready_o} !== 4'b0000) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %b expected 0000", {tag_en_o, tag_data_o, done_o, ready_o});
    end
    @(posedge clk_i);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    f0 = rx_frames;
    @(posedge clk_i); #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", ready_o); end
    exp_d = '0; exp_e = '0; exp_done = '0; exp_ready = '0;
    lc = add_frame(0, 1'b0, 4'd1, 1'b1, 4'd1, 8'h01);
    exp_ready[lc] = 1'b1;
    issue(1'b0, 4'd1, 1'b1, 4'd1, 8'h01);
    capture(lc + 1);
    checks++; if (cap_d !== exp_d) begin errors++; $display("[TB] FAIL midreset_new_data: got %h expected %h", cap_d, exp_d); end
    checks++; if (cap_e !== exp_e) begin errors++; $display("[TB] FAIL midreset_new_en: got %h expected %h", cap_e, exp_e); end
    checks++; if (cap_done !== exp_done) begin errors++; $display("[TB] FAIL midreset_new_done: got %h expected %h", cap_done, exp_done); end
    checks++; if (cap_ready !== exp_ready) begin errors++; $display("[TB] FAIL midreset_new_ready: got %h expected %h", cap_ready, exp_ready); end
    checks++; if (rx_frames - f0 !== 1 || {rx_id, rx_len, rx_payload} !== {4'd1, 4'd1, 8'h01}) begin
      errors++; $display("[TB] FAIL midreset_rx: got frames %0d id %0d len %0d payload %h expected frames 1 id 1 len 1 payload 01",
                         rx_frames - f0, rx_id, rx_len, rx_payload);
    end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_len0();
    test_master_reset();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
